pwm_duty_decoder: RTL and testbench

//  Receive-side counterpart of the team's PWM pulse generators (solid-square, X/Y drive).
//  - Samples a PWM line, measures high-time and period between consecutive rising edges.
//  - Reports each completed frame as one registered measurement.
//  - Flags lines stuck at constant 0 % or 100 % duty. Used for loop-back checking of generated drive.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_duty_decoder_if.sv | 29 ++
 rtl/pwm_sync_filter.sv | 65 ++++++
 rtl/pwm_duty_decoder.sv | 136 +++++++++++++
 tb/tb_pwm_duty_decoder.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: decoder state encoding, default counter width
// and the counter saturation value helper.
package pwm_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    MEAS,
    STUCK
  } dec_state_t;

  // Largest value a counter of width w can hold.
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_duty_decoder_if.sv
// Measurement result bundle of the PWM duty decoder.
// master: the decoder driving results; slave: the consumer.
interface pwm_duty_decoder_if import pwm_pkg::*; #(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
);

  logic             meas_valid;
  logic [CNT_W-1:0] meas_high;
  logic [CNT_W-1:0] meas_period;
  logic             stuck;
  logic             stuck_level;

  modport master (
    output meas_valid,
    output meas_high,
    output meas_period,
    output stuck,
    output stuck_level
  );

  modport slave (
    input meas_valid,
    input meas_high,
    input meas_period,
    input stuck,
    input stuck_level
  );

endinterface

// File: rtl/pwm_sync_filter.sv
// Synchronises the asynchronous PWM line into sysclk and produces the
// sampled level s and its rising-edge pulse.
// Optional glitch filter enabled by defining GLITCH_FILTER_EN: s follows
// the synchronised line only after FILT_LEN consecutive differing cycles.
module pwm_sync_filter #(
  parameter int unsigned SYNC_STAGES = 2
`ifdef GLITCH_FILTER_EN
  , parameter int unsigned FILT_LEN = 4
`endif
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   s_d;

  // Multi-flop synchroniser for the asynchronous line.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
  localparam int unsigned FILT_W = $clog2(FILT_LEN + 1);

  logic [FILT_W-1:0] filt_cnt;
  logic              s_q;

  // Count consecutive cycles the line disagrees with s; adopt the new
  // level on the FILT_LEN-th such cycle.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt <= '0;
      s_q      <= 1'b0;
    end else if (sync_out == s_q) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_W'(FILT_LEN - 1)) begin
      filt_cnt <= '0;
      s_q      <= sync_out;
    end else begin
      filt_cnt <= filt_cnt + FILT_W'(1);
    end
  end

  assign s = s_q;
`else
  assign s = sync_out;
`endif

  // Previous-cycle level for edge detection.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) s_d <= 1'b0;
    else        s_d <= s;
  end

  assign rise = s & ~s_d;

endmodule

// File: rtl/pwm_duty_decoder.sv
// PWM duty decoder: measures high time and rise-to-rise period of each
// frame on pwm_in, strobes one registered result per frame and reports a
// single timeout measurement for lines stuck at 0 % or 100 % duty.
// Optional glitch filter enabled by defining GLITCH_FILTER_EN.
module pwm_duty_decoder import pwm_pkg::*; #(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
`ifdef GLITCH_FILTER_EN
  , parameter int unsigned FILT_LEN  = 4
`endif
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               pwm_in,
  pwm_duty_decoder_if.master meas
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  dec_state_t       state, state_nxt;
  logic [CNT_W-1:0] per_cnt, per_nxt;
  logic [CNT_W-1:0] hi_cnt, hi_nxt;
  logic [CNT_W-1:0] high_q, high_nxt;
  logic [CNT_W-1:0] period_q, period_nxt;
  logic             valid_q, valid_nxt;
  logic             stuck_q, stuck_nxt;
  logic             lvl_q, lvl_nxt;
  logic             s, rise, timeout;

  pwm_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef GLITCH_FILTER_EN
    , .FILT_LEN(FILT_LEN)
`endif
  ) u_sync (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .pwm_in(pwm_in),
    .s     (s),
    .rise  (rise)
  );

  assign timeout = (per_cnt == CNT_MAX);

  // State register.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: a rise always wins over a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = MEAS;
      MEAS:    if (!rise && timeout) state_nxt = STUCK;
      STUCK:   if (rise) state_nxt = MEAS;
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  // Next values of counters and result registers.
  always_comb begin
    per_nxt    = per_cnt;
    hi_nxt     = hi_cnt;
    high_nxt   = high_q;
    period_nxt = period_q;
    stuck_nxt  = stuck_q;
    lvl_nxt    = lvl_q;
    valid_nxt  = 1'b0;
    if (!enable) begin
      per_nxt = '0;
      hi_nxt  = '0;
    end else begin
      case (state)
        IDLE, STUCK: begin
          if (rise) begin
            per_nxt = CNT_ONE;
            hi_nxt  = CNT_ONE;
          end
        end
        MEAS: begin
          if (rise) begin
            period_nxt = per_cnt;
            high_nxt   = hi_cnt;
            stuck_nxt  = 1'b0;
            valid_nxt  = 1'b1;
            per_nxt    = CNT_ONE;
            hi_nxt     = CNT_ONE;
          end else if (timeout) begin
            period_nxt = '1;
            high_nxt   = {CNT_W{s}};
            stuck_nxt  = 1'b1;
            lvl_nxt    = s;
            valid_nxt  = 1'b1;
          end else begin
            per_nxt = per_cnt + CNT_ONE;
            hi_nxt  = hi_cnt + CNT_W'(s);
          end
        end
        default: ;
      endcase
    end
  end

  // Counter and result registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt  <= '0;
      hi_cnt   <= '0;
      high_q   <= '0;
      period_q <= '0;
      stuck_q  <= 1'b0;
      lvl_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      per_cnt  <= per_nxt;
      hi_cnt   <= hi_nxt;
      high_q   <= high_nxt;
      period_q <= period_nxt;
      stuck_q  <= stuck_nxt;
      lvl_q    <= lvl_nxt;
      valid_q  <= valid_nxt;
    end
  end

  assign meas.meas_valid  = valid_q;
  assign meas.meas_high   = high_q;
  assign meas.meas_period = period_q;
  assign meas.stuck       = stuck_q;
  assign meas.stuck_level = lvl_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Testbench for pwm_duty_decoder: directed frame scenarios plus random
// frames, compared every cycle against a frame-level reference model.
module tb_pwm_duty_decoder;

  logic sysclk = 1'b0;
  logic rst_n;
  logic enable;
  logic pwm_in;

  pwm_duty_decoder_if #(.CNT_W(8)) meas_if ();

  pwm_duty_decoder #(
    .CNT_W(8),
    .SYNC_STAGES(2)
`ifdef GLITCH_FILTER_EN
    , .FILT_LEN(4)
`endif
  ) dut (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .enable(enable),
    .pwm_in(pwm_in),
    .meas  (meas_if)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: line pipeline plus a frame recorded as a queue of
  // sampled levels since the arming rise.
  localparam int FILT_LEN = 4;
  localparam int MAX_PER  = 255;

  bit sh0, sh1, s_prev, filt_s;
  bit hist[$];
  bit frame[$];
  bit armed, stuck_ep;
  int exp_valid, exp_high, exp_period, exp_stuck, exp_lvl;

  task automatic model_reset();
    sh0 = 0; sh1 = 0; s_prev = 0; filt_s = 0;
    hist.delete(); frame.delete();
    armed = 0; stuck_ep = 0;
    exp_valid = 0; exp_high = 0; exp_period = 0; exp_stuck = 0; exp_lvl = 0;
  endtask

  task automatic model_step(input bit v, input bit en);
    bit s_now, rise_now, syn, all_diff;
    int hsum;
`ifdef GLITCH_FILTER_EN
    s_now = filt_s;
`else
    s_now = sh1;
`endif
    rise_now  = s_now && !s_prev;
    exp_valid = 0;
    if (!en) begin
      armed = 0; stuck_ep = 0; frame.delete();
    end else if (rise_now) begin
      if (armed && !stuck_ep) begin
        hsum = 0;
        foreach (frame[i]) hsum += int'(frame[i]);
        exp_period = frame.size();
        exp_high   = hsum;
        exp_stuck  = 0;
        exp_valid  = 1;
      end
      armed = 1; stuck_ep = 0;
      frame.delete();
      frame.push_back(1'b1);
    end else if (armed && !stuck_ep) begin
      if (frame.size() == MAX_PER) begin
        exp_period = MAX_PER;
        exp_high   = s_now ? MAX_PER : 0;
        exp_stuck  = 1;
        exp_lvl    = int'(s_now);
        exp_valid  = 1;
        stuck_ep   = 1;
      end else begin
        frame.push_back(s_now);
      end
    end
    s_prev = s_now;
    syn = sh1;
    hist.push_back(syn);
    if (hist.size() > FILT_LEN) void'(hist.pop_front());
    all_diff = (hist.size() == FILT_LEN);
    foreach (hist[i]) if (hist[i] == filt_s) all_diff = 0;
    if (all_diff) filt_s = syn;
    sh1 = sh0;
    sh0 = v;
  endtask

  task automatic compare_all();
    check("meas_valid",  int'(meas_if.meas_valid),  exp_valid);
    check("meas_high",   int'(meas_if.meas_high),   exp_high);
    check("meas_period", int'(meas_if.meas_period), exp_period);
    check("stuck",       int'(meas_if.stuck),       exp_stuck);
    check("stuck_level", int'(meas_if.stuck_level), exp_lvl);
  endtask

  // One sysclk: check results of the last edge, then drive this cycle.
  task automatic cyc(input bit v);
    @(posedge sysclk); #1;
    compare_all();
    pwm_in = v;
    model_step(v, enable);
  endtask

  task automatic frame_drive(input int per, input int hi);
    for (int i = 0; i < per; i++) cyc(i < hi);
  endtask

  task automatic hold_level(input bit v, input int n);
    for (int i = 0; i < n; i++) cyc(v);
  endtask

  // Asynchronous reset pulse in mid-cycle, held for 3 clock edges.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_valid",  int'(meas_if.meas_valid),  0);
    check("reset_high",   int'(meas_if.meas_high),   0);
    check("reset_period", int'(meas_if.meas_period), 0);
    check("reset_stuck",  int'(meas_if.stuck),       0);
    for (int i = 0; i < 3; i++) begin
      @(posedge sysclk); #1;
      compare_all();
    end
    rst_n = 1'b1;
    model_step(pwm_in, enable);
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    pwm_in = 1'b0;
    model_reset();
    repeat (2) @(posedge sysclk);
    #1;
    compare_all();
    rst_n = 1'b1;
    model_step(pwm_in, enable);

    // Near-100 % duty frames.
    for (int f = 0; f < 5; f++) frame_drive(64, 63);
    // Duty change 16 -> 32 of 64.
    for (int f = 0; f < 3; f++) frame_drive(64, 16);
    for (int f = 0; f < 3; f++) frame_drive(64, 32);
    // Stuck low after one pulse.
    frame_drive(10, 4);
    hold_level(1'b0, 600);
    // Stuck high after a rise, then normal frames.
    hold_level(1'b1, 300);
    hold_level(1'b0, 5);
    for (int f = 0; f < 3; f++) frame_drive(64, 20);
    // Reset mid-frame.
    for (int f = 0; f < 2; f++) frame_drive(64, 30);
    frame_drive(20, 30);
    reset_pulse();
    frame_drive(44, 10);
    for (int f = 0; f < 3; f++) frame_drive(64, 30);
    // 1-cycle glitch at cycle 40 of a 64-cycle frame.
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 64; i++) cyc((i < 20) || (i == 40));
    // Enable low for 10 cycles inside a frame.
    for (int i = 0; i < 64; i++) begin
      enable = !(i >= 10 && i < 20);
      cyc(i < 25);
    end
    enable = 1'b1;
    for (int f = 0; f < 3; f++) frame_drive(64, 25);

    // Random frames, occasional long periods and enable drops.
    for (int f = 0; f < 50; f++) begin
      int per, hi;
      per = $urandom_range(2, 140);
      if ($urandom_range(0, 9) == 0) per = $urandom_range(250, 320);
      hi = $urandom_range(1, per - 1);
      frame_drive(per, hi);
      if ($urandom_range(0, 9) == 0) begin
        enable = 1'b0;
        hold_level(pwm_in, $urandom_range(1, 8));
        enable = 1'b1;
      end
    end
    hold_level(1'b0, 10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
